// File: rtl/stream_unary_and_pkg.sv
// Shared types and helpers for the streaming unary-AND packet reducer.
package stream_unary_and_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Width needed to hold a beat count from 0 to max_beats inclusive.
    function automatic int unsigned cw_of(input int unsigned max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/BehavioralUnaryAND.sv
// Per-beat unary AND: one bit that is set only when every bit of the beat is set.
module BehavioralUnaryAND #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] s_data,
    output logic         and_out
);

    always_comb begin
        and_out = &s_data;
    end

endmodule

// File: rtl/stream_unary_and_reducer.sv
// Packet-level AND reduction over a valid/ready beat stream; one result per packet.
// Optional first-zero beat index output enabled by STREAM_UNARY_AND_FIRST_ZERO_EN.
module stream_unary_and_reducer
    import stream_unary_and_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned MAX_BEATS = 16,
    localparam int unsigned CW       = cw_of(MAX_BEATS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [N-1:0]  s_data,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_result,
    output logic [CW-1:0] m_beats,
`ifdef STREAM_UNARY_AND_FIRST_ZERO_EN
    output logic [CW-1:0] m_first_zero,
`endif
    output logic          m_overflow
);

    state_t        state;
    logic          beat_and;
    logic          acc;
    logic          ovf;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          at_max;
    logic          accept;
`ifdef STREAM_UNARY_AND_FIRST_ZERO_EN
    logic [CW-1:0] fz;
    logic          new_zero;
`endif

    BehavioralUnaryAND #(.N(N)) u_beat_and (
        .s_data  (s_data),
        .and_out (beat_and)
    );

    always_comb begin
        s_ready = (state == ACCUM);
        m_valid = (state == HOLD);
        accept  = s_valid && s_ready;
        at_max  = (cnt == CW'(MAX_BEATS));
        cnt_inc = at_max ? cnt : cnt + CW'(1);
`ifdef STREAM_UNARY_AND_FIRST_ZERO_EN
        // acc still high means no zero beat has been seen yet in this packet
        new_zero = acc && !beat_and;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACCUM;
            acc          <= 1'b1;
            cnt          <= '0;
            ovf          <= 1'b0;
            m_result     <= 1'b0;
            m_beats      <= '0;
            m_overflow   <= 1'b0;
`ifdef STREAM_UNARY_AND_FIRST_ZERO_EN
            fz           <= '0;
            m_first_zero <= '0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= acc & beat_and;
                        cnt <= cnt_inc;
                        ovf <= ovf | at_max;
`ifdef STREAM_UNARY_AND_FIRST_ZERO_EN
                        if (new_zero) fz <= cnt;
`endif
                        if (s_last) begin
                            m_result   <= acc & beat_and;
                            m_beats    <= cnt_inc;
                            m_overflow <= ovf | at_max;
`ifdef STREAM_UNARY_AND_FIRST_ZERO_EN
                            m_first_zero <= new_zero ? cnt : fz;
`endif
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        state <= ACCUM;
                        acc   <= 1'b1;
                        cnt   <= '0;
                        ovf   <= 1'b0;
`ifdef STREAM_UNARY_AND_FIRST_ZERO_EN
                        fz    <= '0;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/stream_unary_and_reducer.md
# stream_unary_and_reducer

Streaming reduction stage that consumes a packet of N-bit beats over a valid/ready handshake and produces one AND-reduced result bit per packet. Each beat is AND-reduced across its own bits (the per-beat unary AND), and the per-beat results are AND-accumulated across all beats of the packet. The block sits downstream of word producers in the BasicCombinationalLogic Unary unit and upstream of any packet-level checker that needs one "all ones" verdict per packet.

## Interface
- N, 8: beat width in bits; must be ≥ 1.
- MAX_BEATS, 16: beat count at which the beat counter saturates; must be ≥ 1. CW = $clog2(MAX_BEATS+1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- s_valid  input  1  input beat valid.
- s_ready  output  1  block accepts a beat this cycle.
- s_data  input  N  beat data.
- s_last  input  1  final beat of packet; sampled only on an accepted beat.
- m_valid  output  1  packet result valid.
- m_ready  input  1  downstream accepts the result.
- m_result  output  1  AND of every bit of every beat in the packet.
- m_beats  output  CW  number of beats accepted in the packet, saturated at MAX_BEATS.
- m_overflow  output  1  packet had more than MAX_BEATS beats.
- m_first_zero  output  CW  present only with the macro; see Configuration.

## Operation
- Beat accept: s_valid && s_ready at a rising edge.
- Two-state FSM:
  - ACCUM: s_ready=1, m_valid=0. On each accepted beat: acc <= acc & (&s_data); cnt <= min(cnt+1, MAX_BEATS); ovf <= ovf | (cnt==MAX_BEATS). On an accepted beat with s_last=1: the final values, including this beat, load into the output registers, and the FSM moves to HOLD.
  - HOLD: s_ready=0, m_valid=1, outputs stable. When m_ready=1: go to ACCUM, acc<=1, cnt<=0, ovf<=0.
- A single-beat packet (s_last on the first beat) is legal. The block has no empty-packet concept.
- An all-ones packet yields m_result=1. Any zero bit in any beat yields m_result=0.
- Beats beyond MAX_BEATS are still reduced into acc. Only the count saturates, and the overflow flag records the excess.
- Reset, asserted at any time including mid-packet or in HOLD, discards any partial packet and any pending result.
- Reset values: state=ACCUM, s_ready=1, m_valid=0, m_result=0, m_beats=0, m_overflow=0, m_first_zero=0, acc=1.

## Timing
- Latency: m_valid rises on the edge that accepts the s_last beat, so the result is visible in the following cycle.
- The result holds while m_valid && !m_ready. All m_* outputs are registered and stable until the handshake completes.
- At least one idle input cycle separates packets: s_ready reasserts in the cycle after the m_valid && m_ready handshake.
- s_ready depends only on the FSM state. It has no combinational path from m_ready.
- s_data and s_last are ignored when no beat is accepted.

## Configuration
- Macro: STREAM_UNARY_AND_FIRST_ZERO_EN.
- Defined:
  - Port m_first_zero exists.
  - It holds the 0-based index of the first beat whose unary AND was 0, saturated at MAX_BEATS.
  - It is 0 when m_result=1.
  - It is held and reset exactly like m_beats.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Package stream_unary_and_pkg holds:
  - the state enum (ACCUM, HOLD);
  - a function computing CW from MAX_BEATS.
- One sub-module per beat: BehavioralUnaryAND with parameter N, input s_data, output the per-beat reduction bit.
- FSM, accumulator, counter and output registers are in the top module.

## Test plan
- N=8, one beat 0xFF with s_last, m_ready=1 → next cycle m_valid=1, m_result=1, m_beats=1, m_overflow=0.
- Packet 0xFF, 0xFE, 0xFF (last), with m_ready held 0 for 3 cycles → m_result=0, m_beats=3, first_zero=1 (macro on); outputs stable and s_ready=0 until m_ready=1.
- MAX_BEATS=4, packet of 6 beats of 0xFF → m_result=1, m_beats=4, m_overflow=1.
- Back-to-back packets with s_valid held high → exactly one idle s_ready=0 cycle per packet. No beat is lost or duplicated; both results are correct.
- rst_n pulsed low asynchronously mid-packet after 2 beats containing a zero; then packet 0xFF (last) → m_result=1, m_beats=1. All outputs read their reset values while rst_n=0.
